// File: rtl/lsu_resp_unit_if.sv
// Handshake bundle between the LSU and its neighbours: the EXU command channel,
// the data-memory req/ack port and the write-back result channel.
interface lsu_resp_unit_if;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_data;
    logic [1:0]  lsu_mode;
    logic [2:0]  lsu_op;

    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic        wb_err;

    // master: the surroundings (EXU, memory, write-back); slave: the LSU itself
    modport master (
        output lsu_valid, lsu_addr, lsu_data, lsu_mode, lsu_op,
        input  lsu_ready,
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata,
        input  wb_valid, wb_data, wb_err,
        output wb_ready
    );

    modport slave (
        input  lsu_valid, lsu_addr, lsu_data, lsu_mode, lsu_op,
        output lsu_ready,
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata,
        output wb_valid, wb_data, wb_err,
        input  wb_ready
    );
endinterface

// File: rtl/lsu_resp_unit.sv
// Load/store unit: takes one EXU command at a time, performs it on a req/ack
// data-memory port and returns the aligned/extended result to write-back.
module lsu_resp_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    lsu_resp_unit_if.slave     bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    state_t           state_reg;
    logic             ready_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       off_reg;
    logic [1:0]       size_reg;
    logic             uns_reg;
    logic             store_reg;

    logic             mem_req_reg;
    logic             mem_wen_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;
    logic [3:0]       mem_wmask_reg;
    logic             wb_valid_reg;
    logic [31:0]      wb_data_reg;
    logic             wb_err_reg;

    // ---------------- command decode (IDLE side) ----------------
    logic [1:0]  in_size;
    logic [1:0]  in_off;
    logic        in_mem;
    logic        in_store;
    logic        in_misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_mask;

    assign in_off   = bus.lsu_addr[1:0];
    assign in_mem   = bus.lsu_mode[0];
    assign in_store = (bus.lsu_mode == 2'b11);

    // Unsupported op encodings fall into the word case.
    always_comb begin
        in_size = SZ_W;
        case (bus.lsu_op)
            3'b000, 3'b100: in_size = SZ_B;
            3'b001, 3'b101: in_size = SZ_H;
            default:        in_size = SZ_W;
        endcase
    end

    assign in_misaligned = ((in_size == SZ_H) && in_off[0]) ||
                           ((in_size == SZ_W) && (in_off != 2'b00));

    always_comb begin
        st_wdata = bus.lsu_data;
        case (in_size)
            SZ_B:    st_wdata = {4{bus.lsu_data[7:0]}};
            SZ_H:    st_wdata = {2{bus.lsu_data[15:0]}};
            default: st_wdata = bus.lsu_data;
        endcase
    end

    // Lane enables; only evaluated for aligned accesses, where this equals the shifted mask.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign st_mask[gi] = (in_size == SZ_W) ||
                             ((in_size == SZ_H) && (in_off[1] == LANE[1])) ||
                             ((in_size == SZ_B) && (in_off == LANE));
    end

    // ---------------- load extraction (REQ side) ----------------
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

    assign rd_shift = bus.mem_rdata >> {off_reg, 3'b000};

    always_comb begin
        load_ext = bus.mem_rdata;
        case (size_reg)
            SZ_B:    load_ext = uns_reg ? {24'd0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_H:    load_ext = uns_reg ? {16'd0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            ready_reg     <= 1'b0;
            cnt_reg       <= '0;
            off_reg       <= 2'b00;
            size_reg      <= SZ_W;
            uns_reg       <= 1'b0;
            store_reg     <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_wen_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= '0;
            wb_valid_reg  <= 1'b0;
            wb_data_reg   <= '0;
            wb_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!ready_reg) begin
                        ready_reg <= 1'b1;
                    end else if (bus.lsu_valid) begin
                        ready_reg <= 1'b0;
                        off_reg   <= in_off;
                        size_reg  <= in_size;
                        uns_reg   <= bus.lsu_op[2];
                        store_reg <= in_store;
                        if (!in_mem) begin
                            state_reg    <= ST_RESP;
                            wb_valid_reg <= 1'b1;
                            wb_data_reg  <= bus.lsu_addr;
                            wb_err_reg   <= 1'b0;
                        end else if (in_misaligned) begin
                            state_reg    <= ST_RESP;
                            wb_valid_reg <= 1'b1;
                            wb_data_reg  <= '0;
                            wb_err_reg   <= 1'b1;
                        end else begin
                            state_reg     <= ST_REQ;
                            mem_req_reg   <= 1'b1;
                            mem_wen_reg   <= in_store;
                            mem_addr_reg  <= {bus.lsu_addr[31:2], 2'b00};
                            mem_wdata_reg <= in_store ? st_wdata : 32'd0;
                            mem_wmask_reg <= in_store ? st_mask : 4'b0000;
                        end
                    end
                end

                ST_REQ: begin
                    if (bus.mem_ack || (TO_EN && (cnt_reg == TO_LAST))) begin
                        state_reg     <= ST_RESP;
                        cnt_reg       <= '0;
                        mem_req_reg   <= 1'b0;
                        mem_wen_reg   <= 1'b0;
                        mem_wmask_reg <= 4'b0000;
                        wb_valid_reg  <= 1'b1;
                        // An ack in the final allowed cycle still wins over the timeout.
                        if (bus.mem_ack) begin
                            wb_data_reg <= store_reg ? 32'd0 : load_ext;
                            wb_err_reg  <= 1'b0;
                        end else begin
                            wb_data_reg <= '0;
                            wb_err_reg  <= 1'b1;
                        end
                    end else if (TO_EN) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (bus.wb_ready) begin
                        state_reg    <= ST_IDLE;
                        wb_valid_reg <= 1'b0;
                        ready_reg    <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lsu_ready = ready_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_wen   = mem_wen_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_wmask = mem_wmask_reg;
    assign bus.wb_valid  = wb_valid_reg;
    assign bus.wb_data   = wb_data_reg;
    assign bus.wb_err    = wb_err_reg;

endmodule

// File: tb/tb_lsu_resp_unit.sv
// Directed bench for lsu_resp_unit: pass-through, loads/stores with byte-lane
// alignment, misalignment, timeout, late acks, backpressure and async reset.
module tb_lsu_resp_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    lsu_resp_unit_if bus ();

    lsu_resp_unit #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one command at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [1:0] mode, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.lsu_valid = 1'b1;
        bus.lsu_mode  = mode;
        bus.lsu_op    = op;
        bus.lsu_addr  = addr;
        bus.lsu_data  = data;
        step();
        bus.lsu_valid = 1'b0;
    endtask

    task automatic consume(input string tag);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        check({tag, "_wb_valid_drop"}, 32'(bus.wb_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.lsu_ready), 32'd1);
    endtask

    task automatic run_pass(input string tag, input logic [1:0] mode, input logic [31:0] addr);
        issue(mode, 3'b010, addr, 32'h5555_AAAA);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, "_wb_data"}, bus.wb_data, addr);
        check({tag, "_wb_err"}, 32'(bus.wb_err), 32'd0);
        check({tag, "_no_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_busy"}, 32'(bus.lsu_ready), 32'd0);
        $display("txn %s mode=%b addr=0x%08h wb_data=0x%08h", tag, mode, addr, bus.wb_data);
        consume(tag);
    endtask

    task automatic run_mem(input string tag, input logic [1:0] mode, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] data, input int gap,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic exp_wen, input logic [3:0] exp_mask,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        issue(mode, op, addr, data);
        for (int i = 0; i <= gap; i++) begin
            check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
            check({tag, "_addr"}, bus.mem_addr, exp_addr);
            check({tag, "_wen"}, 32'(bus.mem_wen), 32'(exp_wen));
            check({tag, "_mask"}, 32'(bus.mem_wmask), 32'(exp_mask));
            check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
            check({tag, "_no_wb"}, 32'(bus.wb_valid), 32'd0);
            if (i < gap) step();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hDEAD_DEAD;
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, "_wb_data"}, bus.wb_data, exp_wb);
        check({tag, "_wb_err"}, 32'(bus.wb_err), 32'd0);
        check({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
        $display("txn %s addr=0x%08h rdata=0x%08h wb_data=0x%08h", tag, addr, rdata, bus.wb_data);
        consume(tag);
    endtask

    task automatic run_misalign(input string tag, input logic [1:0] mode, input logic [2:0] op,
                                input logic [31:0] addr);
        issue(mode, op, addr, 32'h1234_5678);
        check({tag, "_no_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, "_wb_err"}, 32'(bus.wb_err), 32'd1);
        check({tag, "_wb_data"}, bus.wb_data, 32'd0);
        $display("txn %s addr=0x%08h wb_err=%0b", tag, addr, bus.wb_err);
        consume(tag);
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        reset          = 1'b0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_addr   = '0;
        bus.lsu_data   = '0;
        bus.lsu_mode   = 2'b00;
        bus.lsu_op     = 3'b000;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        bus.wb_ready   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.lsu_ready), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_wb_err", 32'(bus.wb_err), 32'd0);
        check("rst_wmask", 32'(bus.mem_wmask), 32'd0);
        reset = 1'b1;
        step();
        check("post_rst_ready", 32'(bus.lsu_ready), 32'd1);

        run_pass("pass00", 2'b00, 32'h1234_5678);
        run_pass("pass10", 2'b10, 32'hFFFF_0001);

        //           tag      mode   op      addr          data          gap rdata         mem_addr      wen mask     wdata         wb
        run_mem("lb",     2'b01, 3'b000, 32'h8000_0003, 32'h0,        2, 32'h80AB_CDEF, 32'h8000_0000, 0, 4'b0000, 32'h0,        32'hFFFF_FF80);
        run_mem("lbu",    2'b01, 3'b100, 32'h8000_0003, 32'h0,        2, 32'h80AB_CDEF, 32'h8000_0000, 0, 4'b0000, 32'h0,        32'h0000_0080);
        run_mem("lb_o1",  2'b01, 3'b000, 32'h8000_0001, 32'h0,        0, 32'h80AB_CDEF, 32'h8000_0000, 0, 4'b0000, 32'h0,        32'hFFFF_FFCD);
        run_mem("lh_o2",  2'b01, 3'b001, 32'h8000_0002, 32'h0,        1, 32'h80AB_CDEF, 32'h8000_0000, 0, 4'b0000, 32'h0,        32'hFFFF_80AB);
        run_mem("lhu_o2", 2'b01, 3'b101, 32'h8000_0002, 32'h0,        0, 32'h80AB_CDEF, 32'h8000_0000, 0, 4'b0000, 32'h0,        32'h0000_80AB);
        run_mem("lh_pos", 2'b01, 3'b001, 32'h0000_0010, 32'h0,        0, 32'h1234_7FFF, 32'h0000_0010, 0, 4'b0000, 32'h0,        32'h0000_7FFF);
        run_mem("lw",     2'b01, 3'b010, 32'h1000_0004, 32'h0,        1, 32'hCAFE_F00D, 32'h1000_0004, 0, 4'b0000, 32'h0,        32'hCAFE_F00D);
        run_mem("l_op3",  2'b01, 3'b011, 32'h0000_0040, 32'h0,        0, 32'h8765_4321, 32'h0000_0040, 0, 4'b0000, 32'h0,        32'h8765_4321);
        run_mem("l_op7",  2'b01, 3'b111, 32'h0000_0044, 32'h0,        0, 32'hF000_0081, 32'h0000_0044, 0, 4'b0000, 32'h0,        32'hF000_0081);
        run_mem("sh",     2'b11, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 0, 32'h0,        32'h8000_0000, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        run_mem("sb_o1",  2'b11, 3'b000, 32'h0000_0101, 32'h1234_5678, 1, 32'hFFFF_FFFF, 32'h0000_0100, 1, 4'b0010, 32'h7878_7878, 32'h0);
        run_mem("sw",     2'b11, 3'b010, 32'h0000_0020, 32'hA5A5_1234, 0, 32'h0,        32'h0000_0020, 1, 4'b1111, 32'hA5A5_1234, 32'h0);

        run_misalign("lw_mis", 2'b01, 3'b010, 32'h8000_0001);
        run_misalign("lh_mis", 2'b01, 3'b001, 32'h8000_0003);
        run_misalign("sw_mis", 2'b11, 3'b010, 32'h0000_0002);

        // Timeout: no ack, TIMEOUT_CYCLES = 4.
        issue(2'b01, 3'b010, 32'h0000_0300, 32'h0);
        k = 0;
        while (bus.mem_req && k < 20) begin
            k++;
            step();
        end
        check("to_req_cycles", 32'(k), 32'd4);
        check("to_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("to_wb_err", 32'(bus.wb_err), 32'd1);
        check("to_wb_data", bus.wb_data, 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        step();
        bus.mem_ack = 1'b0;
        check("late_ack_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("late_ack_wb_data", bus.wb_data, 32'd0);
        check("late_ack_wb_err", 32'(bus.wb_err), 32'd1);
        check("late_ack_no_req", 32'(bus.mem_req), 32'd0);
        $display("txn timeout req_cycles=%0d wb_err=%0b", k, bus.wb_err);
        consume("to");
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("idle_ack_ready", 32'(bus.lsu_ready), 32'd1);
        check("idle_ack_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("idle_ack_req", 32'(bus.mem_req), 32'd0);

        // Backpressure: result must hold while write-back stalls.
        issue(2'b10, 3'b010, 32'hCAFE_0001, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_wb_valid", 32'(bus.wb_valid), 32'd1);
            check("bp_wb_data", bus.wb_data, 32'hCAFE_0001);
            check("bp_ready", 32'(bus.lsu_ready), 32'd0);
            step();
        end
        $display("txn backpressure wb_data=0x%08h", bus.wb_data);
        consume("bp");

        // Asynchronous reset while an access is outstanding.
        issue(2'b01, 3'b010, 32'h0000_0400, 32'h0);
        check("rstreq_req_before", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstreq_req_drop", 32'(bus.mem_req), 32'd0);
        check("rstreq_ready", 32'(bus.lsu_ready), 32'd0);
        check("rstreq_wb_valid", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("rstreq_ready_after", 32'(bus.lsu_ready), 32'd1);
        check("rstreq_req_after", 32'(bus.mem_req), 32'd0);
        $display("txn reset_mid_req lsu_ready=%0b", bus.lsu_ready);

        run_pass("pass_after_rst", 2'b00, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
